// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-word imem requests
// and buffers returned words in a 2-entry FIFO ahead of decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_t;

  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_req_pc;

  logic [31:0] r_buf_inst [2];
  logic [31:0] r_buf_pc   [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_outstanding;
  logic        w_credit;
  logic        w_issue;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_redir_pc;
  logic        w_unused_rpc;

  assign w_unused_rpc  = ^redirect_pc[1:0];
  assign w_redir_pc    = {redirect_pc[31:2], 2'b00};

  // WAIT and DRAIN both hold the single in-flight request
  assign w_outstanding = (r_state != S_REQ);
  assign w_credit      = ({1'b0, r_count} + {2'b00, w_outstanding}) < DEPTH;

  assign imem_req  = ~reset & (r_state == S_REQ) & w_credit;
  assign imem_addr = r_pc;
  assign w_issue   = imem_req & imem_gnt;

  assign w_push = (r_state == S_WAIT) & imem_rvalid & ~redirect_valid;
  assign w_pop  = inst_valid & inst_ready;

  assign inst_valid = (r_count != 2'd0);
  assign inst_out   = r_buf_inst[r_rd_ptr];
  assign inst_pc    = r_buf_pc[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      S_REQ: begin
        if (w_issue) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = redirect_valid ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
        end else if (redirect_valid) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
    if (redirect_valid) begin
      w_pc_nxt = w_redir_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_issue) begin
        r_req_pc <= r_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_buf_inst[0] <= 32'd0;
      r_buf_inst[1] <= 32'd0;
      r_buf_pc[0]   <= 32'd0;
      r_buf_pc[1]   <= 32'd0;
    end else if (redirect_valid) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_inst[r_wr_ptr] <= imem_rdata;
        r_buf_pc[r_wr_ptr]   <= r_req_pc;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
